// File: rtl/simple_rr_sched_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | simple_rr_sched_pkg : shared types/constants for the RR scheduler |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
package simple_rr_sched_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int ROUTER_PORTS = 4;
  localparam int DST_W        = $clog2(ROUTER_PORTS);
  localparam int CNT_W        = 4;

  // Index width that stays legal for a single requester.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/simple_rr_sched_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | simple_rr_sched_if : requester-side and router-side signal bundle |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
interface simple_rr_sched_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  import simple_rr_sched_pkg::*;

  logic                      en;
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ*DATA_W-1:0]   req_data;
  logic [N_REQ*DST_W-1:0]    req_dst;
  logic [N_REQ-1:0]          req_ready;
  logic                      in_valid;
  logic [DATA_W-1:0]         in_data;
  logic [DST_W-1:0]          in_src;
  logic                      busy;

  modport master (
    output en, req_valid, req_data, req_dst,
    input  req_ready, in_valid, in_data, in_src, busy
  );

  modport slave (
    input  en, req_valid, req_data, req_dst,
    output req_ready, in_valid, in_data, in_src, busy
  );

endinterface
`default_nettype wire

// File: rtl/simple_rr_pick.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | simple_rr_pick : first set request at or after ptr, modulo N_REQ  |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module simple_rr_pick
  import simple_rr_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = ptr_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    sum  = '0;
    cand = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(N_REQ)) begin
        sum = sum - (PTR_W+1)'(N_REQ);
      end
      cand = sum[PTR_W-1:0];
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/simple_rr_sched.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | simple_rr_sched : burst-limited round-robin feeder for a router   |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module simple_rr_sched
  import simple_rr_sched_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  simple_rr_sched_if.slave  bus
);

  localparam int PTR_W = ptr_w(N_REQ);

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic               in_valid_q, in_valid_d;
  logic [DATA_W-1:0]  in_data_q, in_data_d;
  logic [DST_W-1:0]   in_src_q, in_src_d;

  logic [DATA_W-1:0]  data_arr [N_REQ];
  logic [DST_W-1:0]   dst_arr  [N_REQ];

  logic [PTR_W-1:0]   owner_inc;
  logic [PTR_W-1:0]   pick_ptr;
  logic [N_REQ-1:0]   pick_gnt;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;
  logic               hold;
  logic [N_REQ-1:0]   grant_vec;
  logic [PTR_W-1:0]   grant_idx;
  logic               xfer;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
    assign dst_arr[gi]  = bus.req_dst[gi*DST_W +: DST_W];
  end

  assign owner_inc = (owner_q == PTR_W'(N_REQ-1)) ? '0 : owner_q + PTR_W'(1);
  // Once a burst ends, re-arbitration starts just past the owner, so a lone
  // requester may win again without a bubble.
  assign pick_ptr  = (state_q == BURST) ? owner_inc : rr_ptr_q;
  assign hold      = (state_q == BURST) && bus.req_valid[owner_q]
                     && (burst_cnt_q < CNT_W'(MAX_BURST));

  simple_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req (bus.req_valid),
    .ptr (pick_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    grant_vec   = '0;
    grant_idx   = owner_q;
    xfer        = 1'b0;
    if (bus.en && !reset) begin
      if (hold) begin
        grant_vec[owner_q] = 1'b1;
        xfer               = 1'b1;
        burst_cnt_d        = burst_cnt_q + CNT_W'(1);
      end else if (pick_any) begin
        grant_vec   = pick_gnt;
        grant_idx   = pick_idx;
        xfer        = 1'b1;
        owner_d     = pick_idx;
        burst_cnt_d = CNT_W'(1);
        state_d     = BURST;
        if (state_q == BURST) begin
          rr_ptr_d = owner_inc;
        end
      end else if (state_q == BURST) begin
        state_d  = IDLE;
        rr_ptr_d = owner_inc;
      end
    end else if (state_q == BURST) begin
      state_d  = IDLE;
      rr_ptr_d = owner_inc;
    end
  end

  always_comb begin
    in_valid_d = xfer;
    in_data_d  = xfer ? data_arr[grant_idx] : in_data_q;
    in_src_d   = xfer ? dst_arr[grant_idx]  : in_src_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      in_valid_q  <= 1'b0;
      in_data_q   <= '0;
      in_src_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      in_valid_q  <= in_valid_d;
      in_data_q   <= in_data_d;
      in_src_q    <= in_src_d;
    end
  end

  assign bus.req_ready = grant_vec;
  assign bus.in_valid  = in_valid_q;
  assign bus.in_data   = in_data_q;
  assign bus.in_src    = in_src_q;
  assign bus.busy      = (state_q == BURST);

endmodule
`default_nettype wire

// File: doc/simple_rr_sched.md
SIMPLE_RR_SCHED -- requirements
Module: simple_rr_sched

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the 4-port router input.
REQ-002 Parameter DATA_W, default 8: width of the data payload.
REQ-003 Parameter MAX_BURST, default 4: maximum consecutive grants to one requester; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  scheduler enable; when 0, no grants are issued.
REQ-007 req_valid  input  N_REQ  per-requester transfer request.
REQ-008 req_data  input  N_REQ*DATA_W  per-requester payload; requester i occupies slice [i*DATA_W +: DATA_W].
REQ-009 req_dst  input  N_REQ*2  per-requester destination port 0..3; requester i occupies slice [2*i +: 2].
REQ-010 req_ready  output  N_REQ  one-hot-or-zero grant; a transfer occurs when req_valid[i] and req_ready[i] are both 1.
REQ-011 in_valid  output  1  router input valid.
REQ-012 in_data  output  DATA_W  router input data.
REQ-013 in_src  output  2  router destination select.
REQ-014 busy  output  1  1 while a burst owner is held (state BURST).

Function
REQ-015 req_ready SHALL be combinational from req_valid, en, state, owner and rr_ptr; at most one bit set.
REQ-016 req_ready[i] SHALL never be 1 while req_valid[i] is 0.
REQ-017 State IDLE: if en=1 and any req_valid, the first valid requester at or after rr_ptr (modulo N_REQ) is granted; owner := that index; burst_cnt := 1; next state BURST.
REQ-018 State BURST: owner keeps the grant while req_valid[owner]=1, en=1 and burst_cnt < MAX_BURST; burst_cnt increments on each granted transfer.
REQ-019 In BURST, if the owner drops valid or burst_cnt = MAX_BURST, the following transfer is arbitrated as in IDLE, with rr_ptr = owner+1; if no other requester is valid, the same owner may be re-granted and burst_cnt restarts at 1.
REQ-020 BURST -> IDLE when no requester is valid, or en=0; rr_ptr := owner+1 modulo N_REQ on that transition.
REQ-021 Arbitration SHALL be handoff-free: a new owner is granted in the same cycle the previous burst ends, with no bubble cycle.
REQ-022 On a transfer, in_valid, in_data and in_src SHALL be registered from req_valid, req_data and req_dst of the granted requester; latency is exactly 1 cycle.
REQ-023 In a cycle with no transfer, in_valid := 0, and in_data and in_src hold their previous values.
REQ-024 en deasserting SHALL take effect in the same cycle: req_ready = 0 and no transfer occurs.
REQ-025 rr_ptr and owner are $clog2(N_REQ) bits wide and wrap from N_REQ-1 to 0; burst_cnt is 4 bits and saturates at MAX_BURST.
REQ-026 With MAX_BURST=1, grants SHALL rotate strictly every transfer among the valid requesters.

Reset
REQ-027 While reset=1, regardless of clk: state=IDLE, rr_ptr=0, owner=0, burst_cnt=0, in_valid=0, in_data=0, in_src=0, busy=0, req_ready=0.
REQ-028 Reset asserted mid-burst SHALL abort the burst; no transfer is reported for that cycle; the first post-reset grant starts from requester 0.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE, BURST), the router port count (4) and the destination width (2).
REQ-030 Round-robin first-valid selection SHALL be a sub-module, simple_rr_pick (inputs: request vector and pointer; output: one-hot grant and index).

Verification
REQ-031 Reset, then req_valid=4'b0001, req_data[0]=0xA5, req_dst[0]=2 -> req_ready=4'b0001, and the next cycle in_valid=1, in_data=0xA5, in_src=2.
REQ-032 All 4 requesters valid continuously, MAX_BURST=4 -> 4 grants to requester 0, then 4 to requester 1, then 2, then 3, then 0 again, with no idle cycle.
REQ-033 Requester 1 alone valid for 10 cycles, MAX_BURST=4 -> 10 consecutive transfers with no bubble, and burst_cnt restarting after 4.
REQ-034 During a burst by requester 2, drop en for 2 cycles -> req_ready=0 and in_valid=0 one cycle later; after en returns, the grant goes to requester 3 if valid.
REQ-035 Assert reset in the 3rd cycle of a burst by requester 3 -> all outputs 0 immediately; after release with all valid, the first grant goes to requester 0.
REQ-036 Random valid patterns over 10k cycles -> scoreboard matches each accepted (data, dst) against router in_* one cycle later, and no requester waits more than 3*MAX_BURST grants.
